// File: rtl/subsq_pkg.sv
// subsq_pkg: shared widths, default seed and controller state encoding
package subsq_pkg;
    localparam int ROOT_W  = 4;
    localparam int STATE_W = 8;
    localparam logic [STATE_W-1:0] DEFAULT_SEED = 8'd17;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_SEED  = 3'd1;
    localparam state_t S_LOAD  = 3'd2;
    localparam state_t S_TURN  = 3'd3;
    localparam state_t S_CHECK = 3'd4;
    localparam state_t S_OVER  = 3'd5;
endpackage

// File: rtl/subsq_game_ctrl_if.sv
// subsq_game_ctrl_if: move valid/ready handshake between a player and the controller
interface subsq_game_ctrl_if;
    import subsq_pkg::*;
    logic              move_valid;
    logic [ROOT_W-1:0] move_root;
    logic              move_ready;
    modport master (output move_valid, move_root, input move_ready);
    modport slave  (input move_valid, move_root, output move_ready);
endinterface

// File: rtl/subsq_move_check.sv
// subsq_move_check: squares a root and tests it against the remaining game value
module subsq_move_check
    import subsq_pkg::*;
(
    input  logic [ROOT_W-1:0]  root_i,
    input  logic [STATE_W-1:0] state_i,
    output logic [STATE_W-1:0] sq_o,
    output logic               legal_o,
    output logic [STATE_W-1:0] next_state_o
);
    assign sq_o         = STATE_W'(root_i) * STATE_W'(root_i);
    assign legal_o      = (root_i != '0) && (sq_o <= state_i);
    assign next_state_o = state_i - sq_o;
endmodule

// File: rtl/subsq_game_ctrl.sv
// subsq_game_ctrl: seeds a Subtract-a-Square game, alternates two players and
// applies checked moves until the value hits zero or a turn times out.
module subsq_game_ctrl
    import subsq_pkg::*;
#(
    parameter int unsigned TURN_TIMEOUT = 0,
    parameter int unsigned TO_W         = 32
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_i,
    input  logic               abort_i,
    output logic               enable_rand_o,
    input  logic [STATE_W-1:0] seed_state_i,
    subsq_game_ctrl_if.slave   mv,
    output logic [STATE_W-1:0] game_state_o,
    output logic               player_o,
    output logic               move_ack_o,
    output logic               move_err_o,
    output logic               timeout_o,
    output logic               game_over_o,
    output logic               winner_o,
    output logic [7:0]         move_count_o
);
    state_t             state_q, state_d;
    logic [STATE_W-1:0] game_state_q, game_state_d;
    logic [ROOT_W-1:0]  root_q, root_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [7:0]         move_count_q, move_count_d;
    logic               player_q, player_d, winner_q, winner_d;
    logic               ack_q, ack_d, err_q, err_d, timeout_q, timeout_d, game_over_q;
    logic [STATE_W-1:0] sq, next_gs;
    logic               legal;

    subsq_move_check u_check (
        .root_i       (root_q),
        .state_i      (game_state_q),
        .sq_o         (sq),
        .legal_o      (legal),
        .next_state_o (next_gs)
    );

    assign mv.move_ready  = (state_q == S_TURN);
    assign enable_rand_o  = (state_q == S_SEED);

    always_comb begin
        state_d      = state_q;
        game_state_d = game_state_q;
        root_d       = root_q;
        to_cnt_d     = to_cnt_q;
        move_count_d = move_count_q;
        player_d     = player_q;
        winner_d     = winner_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        timeout_d    = 1'b0;
        if (abort_i && state_q != S_IDLE)
            state_d = S_IDLE;
        else
            case (state_q)
                S_IDLE, S_OVER: state_d = start_i ? S_SEED : state_q;
                S_SEED: state_d = S_LOAD;
                S_LOAD: begin
                    game_state_d = (seed_state_i == '0) ? DEFAULT_SEED : seed_state_i;
                    player_d     = 1'b0;
                    winner_d     = 1'b0;
                    move_count_d = '0;
                    to_cnt_d     = '0;
                    state_d      = S_TURN;
                end
                S_TURN: begin
                    // a move presented on the last allowed cycle still wins over the timeout
                    if (mv.move_valid) begin
                        root_d  = mv.move_root;
                        state_d = S_CHECK;
                    end else if (TURN_TIMEOUT != 0 && to_cnt_q == TO_W'(TURN_TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        winner_d  = ~player_q;
                        state_d   = S_OVER;
                    end else
                        to_cnt_d = to_cnt_q + TO_W'(1);
                end
                S_CHECK: begin
                    to_cnt_d = '0;
                    state_d  = S_TURN;
                    err_d    = ~legal;
                    if (legal) begin
                        ack_d        = 1'b1;
                        game_state_d = next_gs;
                        move_count_d = (move_count_q == 8'hFF) ? move_count_q : move_count_q + 8'd1;
                        if (sq == game_state_q) begin
                            winner_d = player_q;
                            state_d  = S_OVER;
                        end else
                            player_d = ~player_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            game_state_q <= '0;
            root_q       <= '0;
            to_cnt_q     <= '0;
            move_count_q <= '0;
            player_q     <= 1'b0;
            winner_q     <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            game_state_q <= game_state_d;
            root_q       <= root_d;
            to_cnt_q     <= to_cnt_d;
            move_count_q <= move_count_d;
            player_q     <= player_d;
            winner_q     <= winner_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            game_over_q  <= (state_d == S_OVER);
        end
    end

    assign game_state_o = game_state_q;
    assign player_o     = player_q;
    assign winner_o     = winner_q;
    assign move_count_o = move_count_q;
    assign move_ack_o   = ack_q;
    assign move_err_o   = err_q;
    assign timeout_o    = timeout_q;
    assign game_over_o  = game_over_q;
endmodule

// File: doc/subsq_game_ctrl.md
# subsq_game_ctrl

Turn-sequencing controller for the Subtract-a-Square game. It requests a starting game state from the random state generator and latches it. It then alternates two players, accepting one move per turn through a valid/ready handshake. Each move subtracts root² from the state after legality checks, and the block declares the winner when the state reaches zero or a player's turn times out.

## Interface
Parameters:
- TURN_TIMEOUT, 0: number of cycles a player may sit in a turn before forfeiting; 0 disables the timeout.
- TO_W, 32: width of the timeout counter.

Ports (reset reset_n, synchronous, active-low; clock clk):
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  new-game request; honoured only in IDLE or OVER.
- abort  in  1  abandon the current game and return to IDLE; ignored in IDLE.
- enable_rand  out  1  one-cycle latch pulse to the random state generator.
- seed_state  in  8  latched starting state from the generator; valid the cycle after enable_rand.
- move_valid  in  1  the current player presents a move.
- move_root  in  4  root r of the move; the amount subtracted is r*r.
- move_ready  out  1  high only in TURN.
- game_state  out  8  remaining value of the game.
- player  out  1  player to move (0 or 1).
- move_ack  out  1  one-cycle pulse: legal move applied.
- move_err  out  1  one-cycle pulse: illegal move rejected.
- timeout  out  1  one-cycle pulse: turn expired.
- game_over  out  1  high in OVER.
- winner  out  1  winning player; valid while game_over is high.
- move_count  out  8  number of legal moves applied in this game; saturates at 255.

## Operation
- States: IDLE, SEED, LOAD, TURN, CHECK, OVER.
- IDLE: all pulses low. start moves to SEED.
- SEED: enable_rand=1 for exactly one cycle, then go to LOAD.
- LOAD:
  - game_state <= seed_state; if seed_state==0, load 17.
  - player<=0, move_count<=0, winner<=0, timeout counter cleared.
  - Go to TURN.
- TURN:
  - move_ready=1. On move_valid&&move_ready, capture move_root and go to CHECK.
  - Otherwise the timeout counter increments each cycle.
- CHECK:
  - sq = move_root*move_root, computed at 8 bits (max 225, no overflow).
  - Illegal if move_root==0 or sq>game_state. On an illegal move: move_err pulse, player unchanged, return to TURN.
  - Legal move:
    - game_state <= game_state-sq; move_ack pulse; move_count increments (saturating).
    - If the new state is 0: winner<=player, go to OVER.
    - Otherwise toggle player and return to TURN.
  - The timeout counter clears on every return to TURN, whether the move was legal or not.
- Timeout: if TURN_TIMEOUT!=0 and the counter reaches TURN_TIMEOUT-1 in TURN with no handshake, then:
  - timeout pulse, winner<=~player, go to OVER.
  - If a handshake occurs in that same cycle, the move takes priority and no timeout fires.
- OVER: game_over=1. game_state, winner and move_count hold. start goes to SEED.
- abort in SEED, LOAD, TURN, CHECK or OVER: go to IDLE next cycle. game_state and move_count hold; game_over drops. abort beats start when both are asserted.
- start outside IDLE/OVER is ignored.

## Timing
- All outputs are registered, except move_ready and enable_rand, which are decoded from the state register.
- Reset values: state IDLE; game_state 0, player 0, winner 0, move_count 0, timeout counter 0; all pulses 0; game_over 0.
- Reset asserted mid-game returns to IDLE on the next edge, with all registers at their reset values.
- Start sequence: start sampled at cycle 0 → SEED in cycle 1 (enable_rand high) → LOAD in cycle 2 → TURN in cycle 3, with game_state showing the seed from cycle 3.
- Move sequence: handshake at cycle t → CHECK at t+1 (move_ready low) → at t+2, ack/err pulse, updated game_state/player, and state TURN or OVER.
- Maximum throughput is one move per 2 cycles.
- Timeout fires at the TURN_TIMEOUT-th cycle spent in TURN; game_over rises the next cycle.

## Structure
- Shared package subsq_pkg holds:
  - the state enum;
  - DEFAULT_SEED=8'd17;
  - ROOT_W=4, STATE_W=8.
- One sub-module, subsq_move_check (combinational): inputs root and state; outputs sq, legal and next_state. The controller instantiates it in CHECK.

## Test plan
- Seed 8'd10, moves root 3 (P0) then root 1 (P1) → game_state 1 then 0; two move_ack pulses; game_over=1; winner=1; move_count=2.
- Seed 8'd5, root 3 → move_err, state stays 5, player stays 0. Then root 0 → move_err again.
- seed_state 0 → game_state 17 at cycle 3; enable_rand high only in cycle 1.
- TURN_TIMEOUT=8, P0 idle → timeout pulse after 8 TURN cycles; winner=1. Repeat with the handshake on cycle 8 → move is accepted and no timeout.
- abort during CHECK → IDLE next cycle. Same cycle start+abort in OVER → IDLE.
- reset_n low for 1 cycle mid-TURN → all outputs return to their reset values on the next edge.
